// File: rtl/astro_genius_pkg.sv
// rtl/astro_genius_pkg.sv - state codes, defaults and output decode shared by the asteroid game controllers
package astro_genius_pkg;

   localparam int TEMPO_PASSO_PADRAO = 50;
   localparam int VIDAS_PADRAO       = 3;

   typedef enum logic [3:0] {
      INICIAL  = 4'd0,
      PREPARA  = 4'd1,
      NOVO_AST = 4'd2,
      ESPERA   = 4'd3,
      REGISTRA = 4'd4,
      COMPARA  = 4'd5,
      ACERTO   = 4'd6,
      MOVE     = 4'd7,
      VERIFICA = 4'd8,
      COLISAO  = 4'd9,
      PERDEU   = 4'd10
   } estado_t;

   typedef struct packed {
      logic zera_dp;
      logic gera_asteroide;
      logic registra_jogada;
      logic move_asteroide;
      logic tiro_hab;
      logic acertou;
      logic colisao;
      logic perdeu;
   } saidas_t;

   // tiro_hab only marks COMPARA; the shot bit itself comes from the datapath register
   function automatic saidas_t decodifica(input estado_t e);
      saidas_t s;
      s = '0;
      case (e)
         PREPARA:  s.zera_dp         = 1'b1;
         NOVO_AST: s.gera_asteroide  = 1'b1;
         REGISTRA: s.registra_jogada = 1'b1;
         COMPARA:  s.tiro_hab        = 1'b1;
         ACERTO:   s.acertou         = 1'b1;
         MOVE:     s.move_asteroide  = 1'b1;
         COLISAO:  s.colisao         = 1'b1;
         PERDEU:   s.perdeu          = 1'b1;
         default:  s = '0;
      endcase
      return s;
   endfunction

   function automatic int largura_timer(input int tempo);
      return (tempo > 1) ? $clog2(tempo) : 1;
   endfunction

endpackage

// File: rtl/contador_passo.sv
// rtl/contador_passo.sv - step timer with synchronous clear, enable and terminal-count flag
module contador_passo #(
   parameter int MODULO = 50,
   parameter int W      = 6
) (
   input  logic clock,
   input  logic reset,
   input  logic limpa,
   input  logic conta,
   output logic fim
);

   localparam logic [W-1:0] ULTIMO = W'(MODULO - 1);

   logic [W-1:0] valor_d;
   logic [W-1:0] valor_q;

   // wraps at the terminal value so the count never leaves 0..MODULO-1
   always_comb begin
      valor_d = valor_q;
      if (limpa) begin
         valor_d = '0;
      end else if (conta) begin
         valor_d = (valor_q == ULTIMO) ? '0 : valor_q + W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valor_q <= '0;
      end else begin
         valor_q <= valor_d;
      end
   end

   assign fim = (valor_q == ULTIMO);

endmodule

// File: rtl/astro_controle.sv
// rtl/astro_controle.sv - control FSM of the asteroid game: spawn, step timing, shots, collisions, lives
module astro_controle #(
   parameter int TEMPO_PASSO = astro_genius_pkg::TEMPO_PASSO_PADRAO,
   parameter int VIDAS       = astro_genius_pkg::VIDAS_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       eh_tiro,
   input  logic       tiro_acertou,
   input  logic       asteroide_na_nave,
   output logic       zera_dp,
   output logic       gera_asteroide,
   output logic       registra_jogada,
   output logic       move_asteroide,
   output logic       tiro,
   output logic       acertou,
   output logic       colisao,
   output logic       perdeu,
   output logic [3:0] db_estado,
   output logic [1:0] db_num_vidas
);

   import astro_genius_pkg::*;

   localparam int TW = largura_timer(TEMPO_PASSO);

   estado_t    estado_d;
   estado_t    estado_q;
   logic [1:0] vidas_d;
   logic [1:0] vidas_q;
   saidas_t    saidas_d;
   saidas_t    saidas_q;
   logic       timer_fim;
   logic       timer_limpa;
   logic       timer_conta;

   // a jogada freezes the timer so a missed shot resumes the step where it stopped
   assign timer_limpa = (estado_q == PREPARA) || (estado_q == NOVO_AST) || (estado_q == MOVE);
   assign timer_conta = (estado_q == ESPERA) && !jogada;

   contador_passo #(
      .MODULO (TEMPO_PASSO),
      .W      (TW)
   ) u_contador_passo (
      .clock (clock),
      .reset (reset),
      .limpa (timer_limpa),
      .conta (timer_conta),
      .fim   (timer_fim)
   );

   always_comb begin
      estado_d = estado_q;
      vidas_d  = vidas_q;
      case (estado_q)
         INICIAL:  if (iniciar) estado_d = PREPARA;
         PREPARA: begin
            vidas_d  = 2'(VIDAS);
            estado_d = NOVO_AST;
         end
         NOVO_AST: estado_d = ESPERA;
         ESPERA: begin
            if (jogada) begin
               estado_d = REGISTRA;
            end else if (timer_fim) begin
               estado_d = MOVE;
            end
         end
         REGISTRA: estado_d = COMPARA;
         COMPARA:  estado_d = (eh_tiro && tiro_acertou) ? ACERTO : ESPERA;
         ACERTO:   estado_d = NOVO_AST;
         MOVE:     estado_d = VERIFICA;
         VERIFICA: estado_d = asteroide_na_nave ? COLISAO : ESPERA;
         COLISAO: begin
            if (vidas_q != 2'd0) vidas_d = vidas_q - 2'd1;
            estado_d = (vidas_q <= 2'd1) ? PERDEU : NOVO_AST;
         end
         PERDEU:   if (iniciar) estado_d = PREPARA;
         default:  estado_d = INICIAL;
      endcase
      saidas_d = decodifica(estado_d);
   end

   // outputs are registered from the next state, so they always match estado_q
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= INICIAL;
         vidas_q  <= '0;
         saidas_q <= '0;
      end else begin
         estado_q <= estado_d;
         vidas_q  <= vidas_d;
         saidas_q <= saidas_d;
      end
   end

   assign zera_dp         = saidas_q.zera_dp;
   assign gera_asteroide  = saidas_q.gera_asteroide;
   assign registra_jogada = saidas_q.registra_jogada;
   assign move_asteroide  = saidas_q.move_asteroide;
   assign tiro            = saidas_q.tiro_hab & eh_tiro;
   assign acertou         = saidas_q.acertou;
   assign colisao         = saidas_q.colisao;
   assign perdeu          = saidas_q.perdeu;
   assign db_estado       = estado_q;
   assign db_num_vidas    = vidas_q;

endmodule
